// File: rtl/obi_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : obi_mem_responder_if
// Description : req/gnt/rvalid data-bus bundle between a cache-side initiator
//               (master) and a memory responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface obi_mem_responder_if;
    logic        req_i;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/obi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : obi_mem_responder
// Description : Word-array memory responder on the req/gnt/rvalid bus.
//               Byte-enabled writes commit at the accept edge; responses
//               travel through a fixed LATENCY-deep pipeline with no
//               backpressure. Out-of-range accesses answer with err_o=1.
//               Optional macro GNT_THROTTLE_EN adds an LFSR-driven grant.
// Revision    : 1.0 - initial release
// ============================================================================
module obi_mem_responder #(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0010_0000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                clk,
    input  logic                reset,
    obi_mem_responder_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);

    // Reject illegal configurations at elaboration time.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || LATENCY < 1 ||
        BASE_ADDR[IDX_W+1:0] != '0 || LFSR_SEED == 16'h0000) begin : g_bad_params
        $error("obi_mem_responder: illegal parameter combination");
    end

    logic             grant;
    logic             accept;
    logic             in_range;
    logic [IDX_W-1:0] word_idx;

    logic             s0_valid;
    logic             s0_err;
    logic [31:0]      s0_data;

    logic [31:0]      mem        [DEPTH];
    logic             stage_valid[LATENCY];
    logic             stage_err  [LATENCY];
    logic [31:0]      stage_data [LATENCY];

    // Reset gates acceptance so a grant left over from before reset cannot
    // let a request through on the first reset edge.
    assign accept   = bus.req_i && grant && reset;
    assign in_range = (bus.addr_i[31:IDX_W+2] == BASE_ADDR[31:IDX_W+2]);
    assign word_idx = bus.addr_i[IDX_W+1:2];

    // Stage-0 payload: write and error responses carry zero data.
    assign s0_valid = accept;
    assign s0_err   = accept && !in_range;
    assign s0_data  = (accept && in_range && !bus.we_i) ? mem[word_idx] : 32'h0;

    // Byte-enabled array write; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && in_range && bus.we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.be_i[b]) begin
                    mem[word_idx][8*b +: 8] <= bus.wdata_i[8*b +: 8];
                end
            end
        end
    end

    for (genvar i = 0; i < LATENCY; i++) begin : g_pipe
        if (i == 0) begin : g_head
            // First stage captures the response at the accept edge.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    stage_valid[0] <= 1'b0;
                    stage_err[0]   <= 1'b0;
                    stage_data[0]  <= 32'h0;
                end else begin
                    stage_valid[0] <= s0_valid;
                    stage_err[0]   <= s0_err;
                    stage_data[0]  <= s0_data;
                end
            end
        end else begin : g_body
            // Later stages shift unconditionally; there is no backpressure.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    stage_valid[i] <= 1'b0;
                    stage_err[i]   <= 1'b0;
                    stage_data[i]  <= 32'h0;
                end else begin
                    stage_valid[i] <= stage_valid[i-1];
                    stage_err[i]   <= stage_err[i-1];
                    stage_data[i]  <= stage_data[i-1];
                end
            end
        end
    end

`ifdef GNT_THROTTLE_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    // Fibonacci feedback from taps 16,14,13,11.
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // Pseudo-random grant gaps to exercise initiator hold behaviour.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr  <= LFSR_SEED;
            grant <= 1'b0;
        end else begin
            lfsr  <= {lfsr[14:0], lfsr_fb};
            grant <= lfsr[0];
        end
    end
`else
    // Grant is held high in every cycle after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            grant <= 1'b0;
        end else begin
            grant <= 1'b1;
        end
    end
`endif

    assign bus.gnt_o    = grant;
    assign bus.rvalid_o = stage_valid[LATENCY-1];
    assign bus.err_o    = stage_err[LATENCY-1];
    assign bus.rdata_o  = stage_data[LATENCY-1];

endmodule
`default_nettype wire
